// File: rtl/universal_shift_reg_if.sv
// Control, data and status bundle for universal_shift_reg.
// master drives mode/data; slave is the shift register itself.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
);
  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             sout_r;
  logic             sout_l;
  logic [CNT_W-1:0] cnt;
  logic             done;

  modport master (
    output en, mode, sin_r, sin_l, pin,
    input  pout, sout_r, sout_l, cnt, done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pin,
    output pout, sout_r, sout_l, cnt, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load)
// with a shift counter that pulses done on each completed WIDTH-shift frame.
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  universal_shift_reg_if.slave bus
);
  localparam logic [1:0]       MODE_HOLD = 2'b00;
  localparam logic [1:0]       MODE_SHR  = 2'b01;
  localparam logic [1:0]       MODE_SHL  = 2'b10;
  localparam logic [1:0]       MODE_LOAD = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q, q_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done, done_nxt;
  logic             shift;

  always_comb begin
    q_nxt    = q;
    cnt_nxt  = cnt;
    done_nxt = 1'b0;
    shift    = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: ;
        MODE_SHR: begin
          q_nxt = {bus.sin_r, q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_SHL: begin
          q_nxt = {q[WIDTH-2:0], bus.sin_l};
          shift = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt   = bus.pin;
          cnt_nxt = '0;
        end
        default: ;
      endcase
    end
    // Either direction advances the same frame counter.
    if (shift) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt  = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
    end
  end

  assign bus.pout   = q;
  assign bus.sout_r = q[0];
  assign bus.sout_l = q[WIDTH-1];
  assign bus.cnt    = cnt;
  assign bus.done   = done;
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised successor to the team's single-bit SISO register. It is a WIDTH-bit universal shift register with these modes:
- hold
- shift right
- shift left
- parallel load

It has a clock enable, serial in/out at both ends, parallel in/out, and a shift counter that flags each completed WIDTH-bit frame. It is used as a serializer/deserializer building block between parallel datapaths and serial links.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
RESET_VAL, 0, value loaded into the register on reset (WIDTH bits).
CNT_W, $clog2(WIDTH), width of the shift counter; derived, not overridden.

Ports:
CLK  input  1  rising-edge clock.
RST_N  input  1  asynchronous active-low reset.
EN  input  1  clock enable; when 0, all state holds.
MODE  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
SIN_R  input  1  serial input entering at the MSB during shift right.
SIN_L  input  1  serial input entering at the LSB during shift left.
PIN  input  WIDTH  parallel load data.
POUT  output  WIDTH  register contents Q.
SOUT_R  output  1  Q[0]; serial output for shift right.
SOUT_L  output  1  Q[WIDTH-1]; serial output for shift left.
CNT  output  CNT_W  number of shifts since the last load, reset, or frame wrap.
DONE  output  1  one-cycle pulse marking completion of a WIDTH-shift frame.

Behaviour:
- Reset (RST_N=0, asynchronous assert, synchronous-to-CLK release):
  - Q=RESET_VAL, CNT=0, DONE=0.
  - Reset asserted mid-frame aborts the frame; no DONE pulse is emitted.
- All state updates on the rising CLK edge.
- POUT, SOUT_R and SOUT_L are driven directly from Q. There is no extra register stage and no combinational path from the inputs.
- EN=0: Q and CNT hold, DONE=0. EN has priority over MODE.
- EN=1, MODE=00 (hold): Q and CNT hold, DONE=0.
- EN=1, MODE=11 (load): Q<=PIN, CNT<=0, DONE<=0. A load mid-frame discards the partial count.
- EN=1, MODE=01 (shift right): Q<={SIN_R, Q[WIDTH-1:1]}.
- EN=1, MODE=10 (shift left): Q<={Q[WIDTH-2:0], SIN_L}.
- Counter, on any shift (01 or 10):
  - If CNT==WIDTH-1: CNT<=0 and DONE<=1.
  - Otherwise: CNT<=CNT+1 and DONE<=0.
- DONE is registered, high for exactly one cycle after the WIDTH-th shift edge. It deasserts on the next edge regardless of EN or MODE.
- Direction changes mid-frame do not reset CNT; the counter counts shifts in either direction.
- Serial latency:
  - A bit on SIN_R at edge k appears on SOUT_R after edge k+WIDTH-1, i.e. it is present on SOUT_R for the cycle following WIDTH shift edges.
  - Symmetric for SIN_L to SOUT_L.
- Back-to-back frames: continuous shifting produces DONE every WIDTH enabled shift cycles with no gap cycle.
- Stalls: EN=0 or hold cycles inside a frame stretch the frame. No shift is lost or duplicated.
- Unknown MODE values (X/Z) are not defined in RTL; the bench must never drive them.

Test Plan:
1. Reset with WIDTH=8, RESET_VAL=8'hA5, RST_N=0 asserted between edges -> POUT=8'hA5, CNT=0, DONE=0 immediately, without waiting for a clock edge.
2. Load PIN=8'h96, then 8 shift-right cycles with SIN_R=0:
   - SOUT_R sequence 0,1,1,0,1,0,0,1.
   - POUT=8'h00 at the end.
   - DONE high exactly one cycle after the 8th shift edge.
   - CNT returns to 0.
3. Shift left, SIN_L serial stream 1,0,1,1,0,0,1,0 (first bit first) -> POUT=8'hB2 after 8 edges; DONE pulses once.
4. Stalls: shift right for 3 cycles, EN=0 for 2 cycles, MODE=00 for 1 cycle, then 5 more shifts -> CNT holds at 3 during the stall; DONE occurs only after the 8th actual shift.
5. Load mid-frame: load PIN=8'h3C when CNT=5 -> CNT=0 and POUT=8'h3C on the next edge; the next DONE comes only after 8 further shifts.
6. Reset mid-frame: RST_N low at CNT=6 -> POUT=RESET_VAL, CNT=0, no DONE; after release, 16 continuous shifts produce DONE at shift 8 and shift 16.
